axis_cpu_controller: RTL and testbench
======================================

AXIS_CPU_CONTROLLER -- requirements
Module: axis_cpu_controller

Interface
REQ-001 SHALL have parameter CODE_ADDR_WIDTH, default 10: instruction address width, matching the datapath.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  level; IDLE->FETCH when 1.
REQ-005 SHALL have port inst_rd_data  input  64  {opcode[15:0], jt[7:0], jf[7:0], k[31:0]}; valid exactly 1 cycle after the PC changes (synchronous ROM).
REQ-006 SHALL have outputs A_sel 3, A_en 1, X_sel 3, X_en 1, PC_sel 2, PC_en 1, B_sel 1, ALU_sel 4, ALU_en 1, ALU_ack 1, regfile_sel 4, regfile_wr_en 1: datapath controls, encoded per axis_cpu_defs.vh macros.
REQ-007 SHALL have inputs eq, gt, ge, set, ALU_vld (1 each): datapath ALU status.
REQ-008 SHALL have outputs imm 32 (operand k), jt 8 (selected branch offset), jmp_correction CODE_ADDR_WIDTH.
REQ-009 SHALL have outputs done 1, ret_a 1, ret_val 32, err 1.

Function
REQ-010 SHALL implement FSM states IDLE, FETCH, EXEC, ALU_WAIT, HALT.
REQ-011 IDLE: all enables 0; start=1 -> FETCH.
REQ-012 FETCH: one cycle with no enables asserted; inst_rd_data is registered into the instruction register at cycle end; -> EXEC.
REQ-013 EXEC: decode the registered instruction with class = opcode[2:0] and mode = opcode[7:5]; imm = k for the entire EXEC/ALU_WAIT span.
REQ-014 LD/LDX IMM (mode 0): A_en/X_en=1 with SEL_IMM, PC_en=1 with PC_SEL_PLUS_1, -> FETCH.
REQ-015 LD/LDX MEM (mode 3): same sequence with SEL_MEM, scratch address = k[3:0].
REQ-016 ST/STX: regfile_wr_en=1, regfile_sel = REGFILE_IN_A or IN_X, PC+1, -> FETCH.
REQ-017 MISC: opcode[7:3]=0 (TAX) -> X_SEL_A; opcode[7:3]=0x10 (TXA) -> A_SEL_X; PC+1.
REQ-018 ALU class: ALU_en pulses 1 for one cycle; ALU_sel = opcode[7:4]; B_sel = IMM if opcode[3]=0, else X; -> ALU_WAIT.
REQ-019 ALU_WAIT on an ALU instruction: on ALU_vld=1, the same cycle asserts ALU_ack=1, A_en=1 with A_SEL_ALU, and PC+1, then -> FETCH; while ALU_vld=0, no enables are asserted.
REQ-020 JA (JMP, opcode[7:4]=0): PC_sel = PLUS_IMM, PC_en=1, -> FETCH.
REQ-021 Conditional JMP (JEQ=1, JGT=2, JGE=3, JSET=4): ALU_en pulse, -> ALU_WAIT. On ALU_vld the block SHALL select jt = field jt if the flag (eq/gt/ge/set respectively) is 1, else field jf, and assert PC_sel = PLUS_JT, PC_en=1, and ALU_ack.
REQ-022 jmp_correction SHALL be a constant of all ones (-1 mod 2^CODE_ADDR_WIDTH), so that target = PC+1+offset; address arithmetic wraps modulo 2^CODE_ADDR_WIDTH.
REQ-023 RET: opcode[4:3]=0 gives ret_val=k, ret_a=0; =2 gives ret_a=1, ret_val=0. In both cases done=1 and the FSM -> HALT.
REQ-024 HALT: done, ret_val and ret_a hold their values; all enables are 0; exit only on rst; start is ignored.
REQ-025 Every enable (A_en, X_en, PC_en, ALU_en, ALU_ack, regfile_wr_en) SHALL be a single-cycle pulse per instruction.
REQ-026 Sequencing latencies: simple instruction 2 cycles; ALU or conditional JMP 3 + N cycles, where N is the number of ALU_vld=0 wait cycles.

Reset
REQ-027 rst=1 -> state IDLE, every enable 0, done 0, err 0, ret_a 0, ret_val 0, imm 0, jt 0, sel outputs 0.
REQ-028 rst asserted in any state, including ALU_WAIT, SHALL abort the current instruction within the same cycle; no enable is asserted in that cycle.

Configuration
REQ-029 Macro AXIS_CPU_ILLEGAL_TRAP_EN.
- Defined: any undecoded opcode (LD/LDX with packet modes, unknown MISC or JMP) -> HALT with err=1, done=1, ret_val=0.
- Undefined: an undecoded opcode executes as a NOP (PC+1, -> FETCH); err is tied to 0.

Verification
REQ-030 rst, start=1, LD #0x1234 then RET #5 -> A_en with A_SEL_IMM and imm=0x1234 in cycle 2; done=1, ret_val=5 at cycle 4.
REQ-031 ADD #3 with ALU_vld delayed 4 cycles -> exactly one ALU_en pulse; no enable asserted for 4 cycles; then A_en, ALU_ack and PC_en in the same cycle.
REQ-032 JEQ jt=2, jf=7 with eq=1, then with eq=0 -> jt output 2, then 7; PC_sel=PLUS_JT and jmp_correction=all ones.
REQ-033 JA at PC=1023 with k=0 (CODE_ADDR_WIDTH=10) -> PC_en with PLUS_IMM; target wraps to 0.
REQ-034 opcode 0x0020 (LD ABS) -> with macro: HALT, err=1; without macro: PC_en with PLUS_1 and execution continues.
REQ-035 rst pulsed during ALU_WAIT -> IDLE the next cycle, no ALU_ack, outputs at reset values.

Source files
------------

// File: rtl/axis_cpu_controller_if.sv
// Datapath-facing bus of the AXIS CPU controller: instruction fetch data,
// datapath control strobes/selects and ALU status flags.
interface axis_cpu_controller_if #(
    parameter int unsigned CODE_ADDR_WIDTH = 10
);
    logic [63:0]                inst_rd_data;
    logic [2:0]                 A_sel;
    logic                       A_en;
    logic [2:0]                 X_sel;
    logic                       X_en;
    logic [1:0]                 PC_sel;
    logic                       PC_en;
    logic                       B_sel;
    logic [3:0]                 ALU_sel;
    logic                       ALU_en;
    logic                       ALU_ack;
    logic [3:0]                 regfile_sel;
    logic                       regfile_wr_en;
    logic                       eq;
    logic                       gt;
    logic                       ge;
    logic                       set;
    logic                       ALU_vld;
    logic [31:0]                imm;
    logic [7:0]                 jt;
    logic [CODE_ADDR_WIDTH-1:0] jmp_correction;

    modport master (
        input  inst_rd_data, eq, gt, ge, set, ALU_vld,
        output A_sel, A_en, X_sel, X_en, PC_sel, PC_en, B_sel, ALU_sel,
               ALU_en, ALU_ack, regfile_sel, regfile_wr_en, imm, jt,
               jmp_correction
    );

    modport slave (
        output inst_rd_data, eq, gt, ge, set, ALU_vld,
        input  A_sel, A_en, X_sel, X_en, PC_sel, PC_en, B_sel, ALU_sel,
               ALU_en, ALU_ack, regfile_sel, regfile_wr_en, imm, jt,
               jmp_correction
    );
endinterface

// File: rtl/axis_cpu_controller.sv
// BPF-style instruction sequencer driving the AXIS CPU datapath.
// Optional macro AXIS_CPU_ILLEGAL_TRAP_EN: undecoded opcodes halt with err=1.
module axis_cpu_controller #(
    parameter int unsigned CODE_ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    axis_cpu_controller_if.master dp,
    output logic                  done,
    output logic                  ret_a,
    output logic [31:0]           ret_val,
    output logic                  err
);
    localparam logic [2:0] A_SEL_IMM = 3'd0, A_SEL_MEM = 3'd1, A_SEL_X = 3'd2, A_SEL_ALU = 3'd3;
    localparam logic [2:0] X_SEL_IMM = 3'd0, X_SEL_MEM = 3'd1, X_SEL_A = 3'd2;
    localparam logic [1:0] PC_SEL_PLUS_1 = 2'd0, PC_SEL_PLUS_JT = 2'd1, PC_SEL_PLUS_IMM = 2'd2;
    localparam logic [3:0] REGFILE_IN_A = 4'd0, REGFILE_IN_X = 4'd1;
    localparam logic [2:0] CLS_LD = 3'd0, CLS_LDX = 3'd1, CLS_ST = 3'd2, CLS_STX = 3'd3,
                           CLS_ALU = 3'd4, CLS_JMP = 3'd5, CLS_RET = 3'd6, CLS_MISC = 3'd7;

    typedef enum logic [2:0] {IDLE, FETCH, EXEC, ALU_WAIT, HALT} state_t;

    state_t                     state_q, state_d;
    logic [63:0]                instr_q, instr_d;
    logic [31:0]                ret_val_q, ret_val_d;
    logic                       ret_a_q, ret_a_d;
    logic                       advance, illegal, taken;
    logic [CODE_ADDR_WIDTH-1:0] jmp_corr;
    logic                       unused;

    logic [15:0] opcode;
    logic [2:0]  cls, mode;
    logic [31:0] k;

    assign opcode   = instr_q[63:48];
    assign cls      = opcode[2:0];
    assign mode     = opcode[7:5];
    assign k        = instr_q[31:0];
    assign jmp_corr = '1;
    assign dp.jmp_correction = jmp_corr;
    assign unused   = ^opcode[15:8];

`ifdef AXIS_CPU_ILLEGAL_TRAP_EN
    logic err_q, err_d;
`endif

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        ret_val_d = ret_val_q;
        ret_a_d   = ret_a_q;
`ifdef AXIS_CPU_ILLEGAL_TRAP_EN
        err_d     = err_q;
`endif
        advance = 1'b0;
        illegal = 1'b0;
        taken   = 1'b0;
        dp.A_sel = '0;  dp.A_en = 1'b0;  dp.X_sel = '0;  dp.X_en = 1'b0;
        dp.PC_sel = '0; dp.PC_en = 1'b0; dp.B_sel = 1'b0; dp.ALU_sel = '0;
        dp.ALU_en = 1'b0; dp.ALU_ack = 1'b0; dp.regfile_sel = '0;
        dp.regfile_wr_en = 1'b0; dp.imm = '0; dp.jt = '0;
        done = 1'b0; ret_a = 1'b0; ret_val = '0; err = 1'b0;

        // rst gates every output combinationally so an abort never leaks an enable
        if (!rst) begin
            case (state_q)
                IDLE: if (start) state_d = FETCH;
                FETCH: begin
                    instr_d = dp.inst_rd_data;
                    state_d = EXEC;
                end
                EXEC: begin
                    dp.imm = k;
                    case (cls)
                        CLS_LD, CLS_LDX: begin
                            if (mode == 3'd0 || mode == 3'd3) begin
                                dp.A_en  = (cls == CLS_LD);
                                dp.X_en  = (cls == CLS_LDX);
                                dp.A_sel = (mode == 3'd0) ? A_SEL_IMM : A_SEL_MEM;
                                dp.X_sel = (mode == 3'd0) ? X_SEL_IMM : X_SEL_MEM;
                                if (mode == 3'd3) dp.regfile_sel = k[3:0];
                                advance = 1'b1;
                            end else begin
                                illegal = 1'b1;
                            end
                        end
                        CLS_ST, CLS_STX: begin
                            dp.regfile_wr_en = 1'b1;
                            dp.regfile_sel   = (cls == CLS_ST) ? REGFILE_IN_A : REGFILE_IN_X;
                            advance = 1'b1;
                        end
                        CLS_ALU: begin
                            dp.ALU_en  = 1'b1;
                            dp.ALU_sel = opcode[7:4];
                            dp.B_sel   = opcode[3];
                            state_d    = ALU_WAIT;
                        end
                        CLS_JMP: begin
                            if (opcode[7:4] == 4'd0) begin
                                dp.PC_sel = PC_SEL_PLUS_IMM;
                                dp.PC_en  = 1'b1;
                                state_d   = FETCH;
                            end else if (opcode[7:4] <= 4'd4) begin
                                dp.ALU_en  = 1'b1;
                                dp.ALU_sel = opcode[7:4];
                                dp.B_sel   = opcode[3];
                                state_d    = ALU_WAIT;
                            end else begin
                                illegal = 1'b1;
                            end
                        end
                        CLS_RET: begin
                            if (opcode[4:3] == 2'd0 || opcode[4:3] == 2'd2) begin
                                done      = 1'b1;
                                ret_a     = opcode[4];
                                ret_val   = opcode[4] ? 32'd0 : k;
                                ret_a_d   = ret_a;
                                ret_val_d = ret_val;
                                state_d   = HALT;
                            end else begin
                                illegal = 1'b1;
                            end
                        end
                        default: begin
                            if (opcode[7:3] == 5'h00) begin
                                dp.X_en  = 1'b1;
                                dp.X_sel = X_SEL_A;
                                advance  = 1'b1;
                            end else if (opcode[7:3] == 5'h10) begin
                                dp.A_en  = 1'b1;
                                dp.A_sel = A_SEL_X;
                                advance  = 1'b1;
                            end else begin
                                illegal = 1'b1;
                            end
                        end
                    endcase
                    if (illegal) begin
`ifdef AXIS_CPU_ILLEGAL_TRAP_EN
                        done      = 1'b1;
                        err       = 1'b1;
                        err_d     = 1'b1;
                        ret_a_d   = 1'b0;
                        ret_val_d = '0;
                        state_d   = HALT;
`else
                        advance = 1'b1;
`endif
                    end
                end
                ALU_WAIT: begin
                    dp.imm     = k;
                    dp.ALU_sel = opcode[7:4];
                    dp.B_sel   = opcode[3];
                    if (dp.ALU_vld) begin
                        dp.ALU_ack = 1'b1;
                        if (cls == CLS_ALU) begin
                            dp.A_en  = 1'b1;
                            dp.A_sel = A_SEL_ALU;
                            advance  = 1'b1;
                        end else begin
                            case (opcode[7:4])
                                4'd1:    taken = dp.eq;
                                4'd2:    taken = dp.gt;
                                4'd3:    taken = dp.ge;
                                4'd4:    taken = dp.set;
                                default: taken = 1'b0;
                            endcase
                            dp.jt     = taken ? instr_q[47:40] : instr_q[39:32];
                            dp.PC_sel = PC_SEL_PLUS_JT;
                            dp.PC_en  = 1'b1;
                            state_d   = FETCH;
                        end
                    end
                end
                HALT: begin
                    done    = 1'b1;
                    ret_a   = ret_a_q;
                    ret_val = ret_val_q;
`ifdef AXIS_CPU_ILLEGAL_TRAP_EN
                    err     = err_q;
`endif
                end
                default: state_d = IDLE;
            endcase
            if (advance) begin
                dp.PC_sel = PC_SEL_PLUS_1;
                dp.PC_en  = 1'b1;
                state_d   = FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            instr_q   <= '0;
            ret_val_q <= '0;
            ret_a_q   <= 1'b0;
`ifdef AXIS_CPU_ILLEGAL_TRAP_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            ret_val_q <= ret_val_d;
            ret_a_q   <= ret_a_d;
`ifdef AXIS_CPU_ILLEGAL_TRAP_EN
            err_q     <= err_d;
`endif
        end
    end
endmodule

// File: tb/tb_axis_cpu_controller.sv
// Directed self-checking bench for axis_cpu_controller; inst_rd_data is driven
// by hand so each instruction is present during its FETCH cycle.
module tb_axis_cpu_controller;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        done, ret_a, err;
    logic [31:0] ret_val;
    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [9:0]  tgt;

    axis_cpu_controller_if #(.CODE_ADDR_WIDTH(10)) bus ();

    axis_cpu_controller #(.CODE_ADDR_WIDTH(10)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .dp      (bus),
        .done    (done),
        .ret_a   (ret_a),
        .ret_val (ret_val),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ins(input logic [15:0] op, input logic [7:0] jt,
                                        input logic [7:0] jf, input logic [31:0] k);
        return {op, jt, jf, k};
    endfunction

    function automatic logic [5:0] enables();
        return {bus.A_en, bus.X_en, bus.PC_en, bus.ALU_en, bus.ALU_ack, bus.regfile_wr_en};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Called in a cycle whose successor is FETCH; returns in the EXEC cycle.
    task automatic fetch_exec(input logic [63:0] instr);
        bus.inst_rd_data = instr;
        tick();
        bus.ALU_vld = 1'b0;
        tick();
    endtask

    task automatic restart();
        rst = 1'b1;
        start = 1'b0;
        tick();
        rst = 1'b0;
        start = 1'b1;
    endtask

    initial begin
        bus.inst_rd_data = '0;
        bus.eq = 1'b0; bus.gt = 1'b0; bus.ge = 1'b0; bus.set = 1'b0;
        bus.ALU_vld = 1'b0;
        tick();
        tick();
        check("rst_enables", enables(), 6'b0);
        check("rst_done_err_ret", {done, err, ret_a, ret_val}, 35'd0);
        check("rst_imm_jt", {bus.imm, bus.jt}, 40'd0);
        check("rst_sels", {bus.A_sel, bus.X_sel, bus.PC_sel, bus.B_sel, bus.ALU_sel, bus.regfile_sel}, 17'd0);

        // LD #0x1234 then RET #5
        rst = 1'b0; start = 1'b1;
        bus.inst_rd_data = ins(16'h0000, 8'd0, 8'd0, 32'h1234);
        #1 check("idle_enables", enables(), 6'b0);
        tick();
        check("fetch_enables", enables(), 6'b0);
        tick();
        check("ld_imm_en", enables(), 6'b101000);
        check("ld_imm_sel", {bus.A_sel, bus.PC_sel}, {3'd0, 2'd0});
        check("ld_imm_val", bus.imm, 32'h1234);
        check("ld_not_done", done, 1'b0);
        fetch_exec(ins(16'h0006, 8'd0, 8'd0, 32'd5));
        check("ret_k_done", {done, ret_a, ret_val}, {1'b1, 1'b0, 32'd5});
        check("ret_k_enables", enables(), 6'b0);
        tick();
        check("halt_hold", {done, ret_a, ret_val}, {1'b1, 1'b0, 32'd5});
        tick();
        check("halt_ignore_start", {done, enables(), ret_val}, {1'b1, 6'b0, 32'd5});

        // ADD #3 with ALU_vld delayed 4 cycles
        restart();
        fetch_exec(ins(16'h0004, 8'd0, 8'd0, 32'd3));
        check("add_exec_en", enables(), 6'b000100);
        check("add_exec_sel", {bus.ALU_sel, bus.B_sel, bus.imm}, {4'd0, 1'b0, 32'd3});
        for (int i = 0; i < 4; i++) begin
            tick();
            check("add_wait_idle", enables(), 6'b0);
            check("add_wait_imm", bus.imm, 32'd3);
        end
        tick();
        bus.ALU_vld = 1'b1;
        #1 check("add_vld_en", enables(), 6'b101010);
        check("add_vld_sel", {bus.A_sel, bus.PC_sel}, {3'd3, 2'd0});

        // ALU AND X: B_sel from opcode[3]
        fetch_exec(ins(16'h005C, 8'd0, 8'd0, 32'd0));
        check("and_x_sel", {bus.ALU_en, bus.ALU_sel, bus.B_sel}, {1'b1, 4'd5, 1'b1});

        // JEQ jt=2 jf=7, eq=1 then eq=0
        restart();
        fetch_exec(ins(16'h0015, 8'd2, 8'd7, 32'd0));
        check("jeq_exec_en", enables(), 6'b000100);
        tick();
        bus.eq = 1'b1; bus.ALU_vld = 1'b1;
        #1 check("jeq_taken_jt", bus.jt, 8'd2);
        check("jeq_taken_ctl", {bus.PC_sel, enables()}, {2'd1, 6'b001010});
        check("jmp_correction", bus.jmp_correction, 10'h3FF);
        fetch_exec(ins(16'h0015, 8'd2, 8'd7, 32'd0));
        tick();
        bus.eq = 1'b0; bus.ALU_vld = 1'b1;
        #1 check("jeq_not_taken_jt", bus.jt, 8'd7);
        check("jeq_not_taken_ctl", {bus.PC_sel, bus.PC_en}, {2'd1, 1'b1});
        // JGT uses gt only
        fetch_exec(ins(16'h0025, 8'd3, 8'd9, 32'd0));
        tick();
        bus.gt = 1'b1; bus.eq = 1'b0; bus.ALU_vld = 1'b1;
        #1 check("jgt_taken_jt", bus.jt, 8'd3);

        // JA at PC=1023, k=0 wraps to 0
        fetch_exec(ins(16'h0005, 8'd0, 8'd0, 32'd0));
        check("ja_ctl", {bus.PC_sel, enables()}, {2'd2, 6'b001000});
        tgt = 10'd1023 + bus.imm[9:0] - bus.jmp_correction;
        check("ja_wrap_target", tgt, 10'd0);

        // Register moves, stores and scratch loads
        fetch_exec(ins(16'h0007, 8'd0, 8'd0, 32'd0));
        check("tax", {bus.X_sel, enables()}, {3'd2, 6'b011000});
        fetch_exec(ins(16'h0087, 8'd0, 8'd0, 32'd0));
        check("txa", {bus.A_sel, enables()}, {3'd2, 6'b101000});
        fetch_exec(ins(16'h0003, 8'd0, 8'd0, 32'd4));
        check("stx", {bus.regfile_sel, enables()}, {4'd1, 6'b001001});
        fetch_exec(ins(16'h0002, 8'd0, 8'd0, 32'd4));
        check("st", {bus.regfile_sel, enables()}, {4'd0, 6'b001001});
        fetch_exec(ins(16'h0061, 8'd0, 8'd0, 32'h29));
        check("ldx_mem", {bus.X_sel, bus.regfile_sel, enables()}, {3'd1, 4'd9, 6'b011000});

        // LD ABS (undecoded)
        fetch_exec(ins(16'h0020, 8'd0, 8'd0, 32'd0));
`ifdef AXIS_CPU_ILLEGAL_TRAP_EN
        check("illegal_trap", {done, err, ret_val, enables()}, {1'b1, 1'b1, 32'd0, 6'b0});
        tick();
        check("illegal_halt", {done, err, enables()}, {1'b1, 1'b1, 6'b0});
        restart();
`else
        check("illegal_nop", {bus.PC_sel, enables(), done, err}, {2'd0, 6'b001000, 1'b0, 1'b0});
`endif
        fetch_exec(ins(16'h0000, 8'd0, 8'd0, 32'd7));
        check("continue_ld", {bus.imm, enables()}, {32'd7, 6'b101000});

        // RET A
        fetch_exec(ins(16'h0016, 8'd0, 8'd0, 32'd99));
        check("ret_a", {done, ret_a, ret_val}, {1'b1, 1'b1, 32'd0});
        tick();
        check("ret_a_hold", {done, ret_a, ret_val}, {1'b1, 1'b1, 32'd0});

        // rst during ALU_WAIT
        restart();
        fetch_exec(ins(16'h0004, 8'd0, 8'd0, 32'd3));
        tick();
        rst = 1'b1; bus.ALU_vld = 1'b1;
        #1 check("abort_same_cycle", enables(), 6'b0);
        tick();
        rst = 1'b0; start = 1'b0;
        #1 check("abort_idle_enables", enables(), 6'b0);
        check("abort_idle_outs", {done, bus.imm, bus.A_sel, bus.ALU_sel}, 40'd0);
        tick();
        check("abort_stays_idle", {enables(), done}, 7'd0);
        bus.ALU_vld = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
